// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// helper that sizes the bit counter from the operand width.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2; clog2(n) bits are enough to hold any value 0..n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder; the only arithmetic element of the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a single
// full-adder cell and a 1-bit carry register.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation are held
// RUN   | WIDTH cycles, one result bit produced per cycle
// DONE  | one-cycle result pulse; a start here begins the next operation
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;

    logic             w_fa_sum;
    logic             w_fa_carry;
    logic             w_last;

    fa_cell u_fa (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .cin   (r_carry),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Sequencer and datapath: load on start, shift one bit per RUN cycle,
    // capture carry/overflow from the MSB step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1; the +1 enters as carry-in.
                        r_a_sh  <= a;
                        r_b_sh  <= sub ? ~b : b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_res   <= {w_fa_sum, r_res[WIDTH-1:1]};
                    r_carry <= w_fa_carry;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // Cell inputs are now the operand MSBs and the cell
                        // sum is the result MSB.
                        r_cout  <= w_fa_carry;
                        r_ovf   <= (r_a_sh[0] == r_b_sh[0]) && (w_fa_sum != r_a_sh[0]);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_res;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit instance for directed cases and a 3-bit
// instance for the exhaustive back-to-back sweep. Expected results are queued
// when an operation is issued and compared when done is observed.
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] sum_v;
        logic       cout_v;
        logic       ovf_v;
    } exp_t;

    logic       clk;
    logic       rst;

    logic       start8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start3, sub3;
    logic [2:0] a3, b3;
    logic       busy3, done3, cout3, ovf3;
    logic [2:0] sum3;

    exp_t q8[$];
    exp_t q3[$];

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .sub   (sub8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8),
        .ovf   (ovf8)
    );

    serial_adder #(.WIDTH(3)) u_dut3 (
        .clk   (clk),
        .rst   (rst),
        .start (start3),
        .sub   (sub3),
        .a     (a3),
        .b     (b3),
        .busy  (busy3),
        .done  (done3),
        .sum   (sum3),
        .cout  (cout3),
        .ovf   (ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model3(input logic [2:0] a, input logic [2:0] b, input logic s);
        exp_t       e;
        logic [2:0] eb;
        logic [3:0] full;
        eb       = s ? ~b : b;
        full     = {1'b0, a} + {1'b0, eb} + {3'b000, s};
        e.sum_v  = {5'b00000, full[2:0]};
        e.cout_v = full[3];
        e.ovf_v  = (a[2] == eb[2]) && (full[2] != a[2]);
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        start3 = 1'b0; sub3 = 1'b0; a3 = '0; b3 = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        checks++;
        if ({busy3, done3, sum3, cout3, ovf3} !== 7'h00) begin
            errors++;
            $display("FAIL reset3: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                     busy3, done3, sum3, cout3, ovf3);
        end
    endtask

    // Issue one operation on the 8-bit instance and check the fixed latency:
    // busy in cycles 1..8, done in cycle 9, results held in cycle 10.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] es, input logic ec, input logic eo, input string name);
        exp_t e;
        e.sum_v = es; e.cout_v = ec; e.ovf_v = eo;
        q8.push_back(e);
        a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy_c%0d: got busy=%b done=%b expected busy=1 done=0",
                         name, c, busy8, done8);
            end
            tick();
        end
        checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_c9: got done=%b busy=%b expected done=1 busy=0", name, done8, busy8);
        end
        checks++;
        if (q8.size() == 0) begin
            errors++;
            $display("FAIL %s_queue: got empty scoreboard expected one entry", name);
        end else begin
            e = q8.pop_front();
            if (sum8 !== e.sum_v || cout8 !== e.cout_v || ovf8 !== e.ovf_v) begin
                errors++;
                $display("FAIL %s_result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                         name, sum8, cout8, ovf8, e.sum_v, e.cout_v, e.ovf_v);
            end
        end
        tick();
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== es || cout8 !== ec || ovf8 !== eo) begin
            errors++;
            $display("FAIL %s_hold_c10: got done=%b busy=%b sum=%h cout=%b ovf=%b expected done=0 busy=0 sum=%h cout=%b ovf=%b",
                     name, done8, busy8, sum8, cout8, ovf8, es, ec, eo);
        end
    endtask

    task automatic test_add();
        op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
    endtask

    task automatic test_add_edges();
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    endtask

    task automatic test_sub();
        op8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
        op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    endtask

    task automatic test_start_during_run();
        exp_t e;
        e.sum_v = 8'h10; e.cout_v = 1'b0; e.ovf_v = 1'b0;
        q8.push_back(e);
        a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (done8 !== ((c == 9) ? 1'b1 : 1'b0) || busy8 !== ((c <= 8) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL ignore_start_c%0d: got done=%b busy=%b expected done=%b busy=%b",
                         c, done8, busy8, (c == 9), (c <= 8));
            end
            if (c == 9) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL ignore_start_queue: got empty scoreboard expected one entry");
                end else begin
                    e = q8.pop_front();
                    if (sum8 !== e.sum_v || cout8 !== e.cout_v || ovf8 !== e.ovf_v) begin
                        errors++;
                        $display("FAIL ignore_start_result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                                 sum8, cout8, ovf8, e.sum_v, e.cout_v, e.ovf_v);
                    end
                end
            end
            if (c == 16) begin
                checks++;
                if (sum8 !== 8'h10) begin
                    errors++;
                    $display("FAIL ignore_start_hold: got sum=%h expected 10", sum8);
                end
            end
            if (c == 4) begin
                a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "pre_rst");
        a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid_run: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_done_c%0d: got done=%b busy=%b expected 0 0", c, done8, busy8);
            end
        end
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "post_rst");
    endtask

    // All 128 (a, b, sub) combinations on the 3-bit instance, each start
    // issued in the done cycle of the previous operation.
    task automatic test_back_to_back();
        exp_t e;
        int   ndone     = 0;
        int   next_idx  = 1;
        int   last_done = 0;
        int   cyc       = 0;
        logic [6:0] op;
        op = 7'd0;
        a3 = op[2:0]; b3 = op[5:3]; sub3 = op[6];
        q3.push_back(model3(op[2:0], op[5:3], op[6]));
        start3 = 1'b1;
        while (ndone < 128 && cyc < 1000) begin
            tick();
            cyc++;
            start3 = 1'b0;
            if (done3 === 1'b1) begin
                checks++;
                if (cyc - last_done != 4) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: got %0d cycles expected 4", ndone, cyc - last_done);
                end
                last_done = cyc;
                checks++;
                if (q3.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_queue_%0d: got empty scoreboard expected one entry", ndone);
                end else begin
                    e = q3.pop_front();
                    if ({5'b00000, sum3} !== e.sum_v || cout3 !== e.cout_v || ovf3 !== e.ovf_v) begin
                        errors++;
                        $display("FAIL b2b_result_%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                                 ndone, sum3, cout3, ovf3, e.sum_v[2:0], e.cout_v, e.ovf_v);
                    end
                end
                ndone++;
                if (next_idx < 128) begin
                    op = 7'(next_idx);
                    next_idx++;
                    a3 = op[2:0]; b3 = op[5:3]; sub3 = op[6];
                    q3.push_back(model3(op[2:0], op[5:3], op[6]));
                    start3 = 1'b1;
                end
            end
        end
        checks++;
        if (ndone != 128) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d done pulses expected 128", ndone);
        end
        tick();
        checks++;
        if (done3 !== 1'b0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got done=%b busy=%b expected 0 0", done3, busy3);
        end
    endtask

    task automatic test_scoreboard_empty();
        checks++;
        if (q8.size() != 0 || q3.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got q8=%0d q3=%0d entries expected 0 0", q8.size(), q3.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_edges();
        test_sub();
        test_start_during_run();
        test_reset_mid_run();
        test_back_to_back();
        test_scoreboard_empty();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
